mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential multiplier (controller plus datapath) between `NUM_REQ` requesters. It accepts operand pairs from requesters and grants one at a time. It launches the multiplier with a single-cycle start, waits for its product-done flag, then returns the product with a one-cycle done pulse to the granted requester. It sits between client blocks and the multiplier core in the arithmetic subsystem.

---
 rtl/mult_arb_pkg.sv | 7 +
 rtl/mult_share_arbiter_rr_picker.sv | 28 ++
 rtl/mult_share_arbiter.sv | 98 +++++++++
 tb/tb_mult_share_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state encoding and parameter defaults for the multiplier-sharing arbiter.
package mult_arb_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT, RESP} state_t;
  localparam int DEF_WIDTH          = 4;
  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;
endpackage

// File: rtl/mult_share_arbiter_rr_picker.sv
// rr_picker: combinational find-first-set of req starting at rr_ptr, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(rr_ptr) + k) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one sequential multiplier among NUM_REQ requesters.
// Optional watchdog on the multiplier completion enabled by MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a,
  input  logic [NUM_REQ*WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [2*WIDTH-1:0]       result,
  output logic                     mult_start,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic                     mult_done,
  input  logic [2*WIDTH-1:0]       mult_product,
  output logic                     err
);
  localparam int IW = $clog2(NUM_REQ);
  state_t             state, nxt;
  logic [IW-1:0]      win, rr_ptr, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any, timeout;
  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req), .rr_ptr(rr_ptr), .gnt(pick_gnt), .idx(pick_idx), .any(pick_any)
  );
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // cnt is zero on the first WAIT cycle, so WAIT lasts exactly TIMEOUT_CYCLES cycles.
  assign timeout = state == WAIT && !mult_done && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      err <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = pick_any ? GRANT : IDLE;
      GRANT:   nxt = LAUNCH;
      LAUNCH:  nxt = WAIT;
      WAIT:    nxt = (mult_done || timeout) ? RESP : WAIT;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign mult_start = state == LAUNCH;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win    <= '0;
      rr_ptr <= '0;
      gnt    <= '0;
      done   <= '0;
      result <= '0;
      mult_a <= '0;
      mult_b <= '0;
    end else begin
      done <= '0;
      if (state == IDLE && pick_any) begin
        win <= pick_idx;
        gnt <= pick_gnt;
      end
      if (state == GRANT)
        for (int i = 0; i < NUM_REQ; i++)
          if (win == IW'(i)) begin
            mult_a <= op_a[i*WIDTH +: WIDTH];
            mult_b <= op_b[i*WIDTH +: WIDTH];
          end
      if (state == WAIT && (mult_done || timeout)) begin
        done   <= gnt;
        result <= mult_done ? mult_product : '0;
      end
      if (state == RESP) begin
        gnt    <= '0;
        rr_ptr <= int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed self-checking bench with a 3-cycle multiplier model.
module tb_mult_share_arbiter;
  localparam int W = 4;
  localparam int N = 4;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] op_a = '0, op_b = '0;
  logic [N-1:0]   gnt, done;
  logic [2*W-1:0] result, mult_product, prod_r, spur_p;
  logic           mult_start, mult_done, err;
  logic [W-1:0]   mult_a, mult_b;
  logic           md_r, spur = 1'b0, mul_en = 1'b1;
  logic [2:0]     mcnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt), .done(done),
    .result(result), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_product(mult_product), .err(err)
  );

  assign mult_done    = md_r | spur;
  assign mult_product = md_r ? prod_r : spur_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= '0;
      md_r <= 1'b0;
      prod_r <= '0;
    end else begin
      md_r <= 1'b0;
      if (mult_start) mcnt <= 3'd3;
      else if (mcnt != 0) begin
        mcnt <= mcnt - 1'b1;
        if (mcnt == 1 && mul_en) begin
          md_r   <= 1'b1;
          prod_r <= mult_a * mult_b;
        end
      end
    end
  end

  task automatic wait_gnt(output logic to);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic to);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done != '0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b want=0000", done); end
    total++; if (mult_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", mult_start); end
    total++; if (mult_a !== 4'h0 || mult_b !== 4'h0) begin bad++; $display("FAIL reset_ops got=%h/%h want=0/0", mult_a, mult_b); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", result); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic to;
    logic gnt_bad = 1'b0;
    int starts = 0;
    op_a[2*W +: W] = 4'd7;
    op_b[2*W +: W] = 4'd9;
    req = 4'b0100;
    @(negedge clk);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
    total++; if (mult_start !== 1'b0) begin bad++; $display("FAIL single_early_start got=%b want=0", mult_start); end
    @(negedge clk);
    total++; if (mult_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b want=1", mult_start); end
    total++; if (mult_a !== 4'd7 || mult_b !== 4'd9) begin bad++; $display("FAIL single_ops got=%0d/%0d want=7/9", mult_a, mult_b); end
    req = '0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mult_start) starts++;
      if (done != '0) begin
        to = 1'b0;
        break;
      end
      if (gnt !== 4'b0100) gnt_bad = 1'b1;
    end
    total++; if (to) begin bad++; $display("FAIL single_done_timeout got=none want=done"); end
    total++; if (done !== 4'b0100) begin bad++; $display("FAIL single_done got=%b want=0100", done); end
    total++; if (result !== 8'd63) begin bad++; $display("FAIL single_result got=%0d want=63", result); end
    total++; if (gnt !== 4'b0100 || gnt_bad) begin bad++; $display("FAIL single_gnt_hold got=%b want=0100", gnt); end
    total++; if (starts != 0) begin bad++; $display("FAIL single_extra_start got=%0d want=0", starts); end
    @(negedge clk);
    total++; if (gnt !== 4'b0000 || done !== 4'b0000) begin bad++; $display("FAIL single_release got=%b/%b want=0000/0000", gnt, done); end
    spur_p = 8'hAA;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    gnt_bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 4'b0000 || gnt !== 4'b0000) gnt_bad = 1'b1;
    end
    total++; if (gnt_bad) begin bad++; $display("FAIL spurious_done got=activity want=none"); end
    total++; if (result !== 8'd63) begin bad++; $display("FAIL spurious_result got=%0d want=63", result); end
  endtask

  task automatic test_wrap;
    logic to;
    op_a[1*W +: W] = 4'd2; op_b[1*W +: W] = 4'd5;
    op_a[3*W +: W] = 4'd3; op_b[3*W +: W] = 4'd4;
    req = 4'b1010;
    wait_gnt(to);
    total++; if (to || gnt !== 4'b1000) begin bad++; $display("FAIL wrap_first_gnt got=%b want=1000", gnt); end
    wait_done(to);
    total++; if (to || done !== 4'b1000 || result !== 8'd12) begin bad++; $display("FAIL wrap_first_done got=%b/%0d want=1000/12", done, result); end
    req = 4'b0010;
    wait_gnt(to);
    total++; if (to || gnt !== 4'b0010) begin bad++; $display("FAIL wrap_second_gnt got=%b want=0010", gnt); end
    wait_done(to);
    total++; if (to || done !== 4'b0010 || result !== 8'd10) begin bad++; $display("FAIL wrap_second_done got=%b/%0d want=0010/10", done, result); end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic to;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] prod [4] = '{8'd2, 8'd6, 8'd12, 8'd20};
    logic [N-1:0] exp_g;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_a[i*W +: W] = W'(i + 1);
      op_b[i*W +: W] = W'(i + 2);
    end
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      exp_g = N'(1) << order[g];
      wait_gnt(to);
      total++; if (to || gnt !== exp_g || !$onehot(gnt)) begin bad++; $display("FAIL rr_gnt%0d got=%b want=%b", g, gnt, exp_g); end
      wait_done(to);
      total++; if (to || done !== exp_g || result !== prod[order[g]]) begin bad++; $display("FAIL rr_done%0d got=%b/%0d want=%b/%0d", g, done, result, exp_g, prod[order[g]]); end
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop;
    logic to;
    op_a[0 +: W] = 4'd15;
    op_b[0 +: W] = 4'd15;
    req = 4'b0001;
    wait_gnt(to);
    total++; if (to || gnt !== 4'b0001) begin bad++; $display("FAIL drop_gnt got=%b want=0001", gnt); end
    repeat (2) @(negedge clk);
    req = '0;
    wait_done(to);
    total++; if (to || done !== 4'b0001) begin bad++; $display("FAIL drop_done got=%b want=0001", done); end
    total++; if (result !== 8'd225) begin bad++; $display("FAIL drop_result got=%0d want=225", result); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_wait;
    logic to;
    logic act = 1'b0;
    mul_en = 1'b0;
    op_a[2*W +: W] = 4'd5;
    op_b[2*W +: W] = 4'd5;
    req = 4'b0100;
    wait_gnt(to);
    total++; if (to || gnt !== 4'b0100) begin bad++; $display("FAIL rstwait_gnt got=%b want=0100", gnt); end
    repeat (2) @(negedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000 || done !== 4'b0000 || mult_start !== 1'b0) begin bad++; $display("FAIL rstwait_ctl got=%b/%b/%b want=0000/0000/0", gnt, done, mult_start); end
    total++; if (mult_a !== 4'h0 || mult_b !== 4'h0 || result !== 8'h00 || err !== 1'b0) begin bad++; $display("FAIL rstwait_data got=%h/%h/%h/%b want=0/0/00/0", mult_a, mult_b, result, err); end
    @(negedge clk);
    rst = 1'b0;
    mul_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done !== 4'b0000 || gnt !== 4'b0000) act = 1'b1;
    end
    total++; if (act) begin bad++; $display("FAIL rstwait_ghost got=activity want=none"); end
    op_a[0 +: W] = 4'd3;
    op_b[0 +: W] = 4'd3;
    req = 4'b0101;
    wait_gnt(to);
    total++; if (to || gnt !== 4'b0001) begin bad++; $display("FAIL rstwait_ptr got=%b want=0001", gnt); end
    wait_done(to);
    total++; if (to || done !== 4'b0001 || result !== 8'd9) begin bad++; $display("FAIL rstwait_done got=%b/%0d want=0001/9", done, result); end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

`ifdef MULT_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic to;
    int n = 0;
    mul_en = 1'b0;
    req = 4'b0010;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mult_start) begin
        to = 1'b0;
        break;
      end
    end
    to = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (err) begin
        to = 1'b0;
        break;
      end
    end
    total++; if (to || n != 9) begin bad++; $display("FAIL timeout_cycles got=%0d want=9", n); end
    total++; if (done !== 4'b0010 || result !== 8'd0) begin bad++; $display("FAIL timeout_done got=%b/%0d want=0010/0", done, result); end
    mul_en = 1'b1;
    req = 4'b0011;
    wait_gnt(to);
    total++; if (to || gnt !== 4'b0001) begin bad++; $display("FAIL timeout_next got=%b want=0001", gnt); end
    req = 4'b0001;
    wait_done(to);
    req = '0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_drop();
    test_reset_wait();
`ifdef MULT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
